// File: rtl/icache_if.sv
// rtl/icache_if.sv - fetch-side and memory-side signal bundle for the instruction cache
//
// Purpose: groups the fetch request/response signals and the refill memory
// port of the icache into one interface.
// Modports:
//   slave  - the cache: takes fetch requests and memory data, drives hit/load
//            and the memory request.
//   master - the environment (fetch stage + memory): drives requests and
//            memory returns, observes hit/load and the memory request.
// Signals:
//   imemREN, imemaddr[31:0], invalidate : fetch request and fence.i pulse
//   ihit, imemload[31:0]                : combinational hit response
//   ramREN, ramaddr[31:0]               : refill memory request
//   ramload[31:0], ram_ready            : refill memory return

interface icache_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        invalidate;
  logic        ramREN;
  logic [31:0] ramaddr;
  logic [31:0] ramload;
  logic        ram_ready;

  modport slave (
    input  imemREN, imemaddr, invalidate, ramload, ram_ready,
    output ihit, imemload, ramREN, ramaddr
  );

  modport master (
    output imemREN, imemaddr, invalidate, ramload, ram_ready,
    input  ihit, imemload, ramREN, ramaddr
  );
endinterface

// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped read-only instruction cache with line refill and perf counters
//
// Purpose: serves fetch reads with a combinational hit path; on a miss a
// two-state FSM refills the whole line in word order 0..BLOCK_WORDS-1.
// Supports whole-cache invalidation and saturating hit/miss counters.
// Ports:
//   CLK        - clock, rising edge
//   nRST       - asynchronous active-low reset
//   cif        - icache_if.slave: fetch request/response and refill memory port
//   hit_count  - saturating count of cycles with ihit=1
//   miss_count - saturating count of refills started

module icache #(
  parameter int NSETS       = 16,
  parameter int BLOCK_WORDS = 2,
  parameter int CNT_W       = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  icache_if.slave          cif,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  localparam int OB = $clog2(BLOCK_WORDS);
  localparam int IB = $clog2(NSETS);
  localparam int TW = 30 - OB - IB;
  localparam logic [OB-1:0]    LAST_WORD = OB'(BLOCK_WORDS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic {IDLE, REFILL} state_t;

  state_t state, next_state;

  logic [OB-1:0] req_off;
  logic [IB-1:0] req_idx;
  logic [TW-1:0] req_tag;

  logic [NSETS-1:0] valid;
  logic [TW-1:0]    tags [NSETS];
  logic [31:0]      data [NSETS][BLOCK_WORDS];

  logic [OB-1:0] word_cnt;
  logic          discard;
  logic [IB-1:0] fill_idx;
  logic [TW-1:0] fill_tag;

  logic hit;
  logic start_refill;
  logic word_done;
  logic line_done;
  logic unused_bits;

  assign req_off     = cif.imemaddr[2+OB-1:2];
  assign req_idx     = cif.imemaddr[2+OB+IB-1:2+OB];
  assign req_tag     = cif.imemaddr[31:2+OB+IB];
  assign unused_bits = ^cif.imemaddr[1:0];

  // No hits while refilling: the line being written may alias the request.
  assign hit = cif.imemREN && (state == IDLE) && !cif.invalidate &&
               valid[req_idx] && (tags[req_idx] == req_tag);
  assign start_refill = (state == IDLE) && cif.imemREN && !hit && !cif.invalidate;
  assign word_done    = (state == REFILL) && cif.ram_ready;
  assign line_done    = word_done && (word_cnt == LAST_WORD);

  // State register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start_refill) next_state = REFILL;
      REFILL:  if (line_done)    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    cif.ihit     = hit;
    cif.imemload = hit ? data[req_idx][req_off] : 32'h0;
    cif.ramREN   = (state == REFILL);
    cif.ramaddr  = (state == REFILL) ? {fill_tag, fill_idx, word_cnt, 2'b00} : 32'h0;
  end

  // Refill bookkeeping, valid bits and counters
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      word_cnt   <= '0;
      discard    <= 1'b0;
      fill_idx   <= '0;
      fill_tag   <= '0;
      valid      <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (start_refill) begin
        word_cnt <= '0;
        discard  <= 1'b0;
        fill_idx <= req_idx;
        fill_tag <= req_tag;
        if (miss_count != CNT_MAX) miss_count <= miss_count + CNT_W'(1);
      end else if (state == REFILL) begin
        // Sticky: an invalidate anywhere in the refill poisons the line.
        if (cif.invalidate) discard <= 1'b1;
        if (word_done) word_cnt <= (word_cnt == LAST_WORD) ? '0 : word_cnt + OB'(1);
      end

      // An invalidate on the final word also keeps the line invalid.
      if (cif.invalidate)              valid <= '0;
      else if (line_done && !discard)  valid[fill_idx] <= 1'b1;

      if (hit && (hit_count != CNT_MAX)) hit_count <= hit_count + CNT_W'(1);
    end
  end

  // Tag and data arrays carry no reset; valid bits alone qualify them.
  always_ff @(posedge CLK) begin
    if (word_done) begin
      data[fill_idx][word_cnt] <= cif.ramload;
      if (word_cnt == LAST_WORD) tags[fill_idx] <= fill_tag;
    end
  end

endmodule

// File: tb/tb_icache.sv
// tb/tb_icache.sv - scoreboard bench for icache against a line-level reference model

module tb_icache;
  localparam int NSETS = 16;
  localparam int BW    = 2;
  localparam int CNT_W = 4;
  localparam int CMAX  = 15;

  logic CLK = 1'b0;
  logic nRST;
  logic [CNT_W-1:0] hit_count, miss_count;

  always #5 CLK = ~CLK;

  icache_if bus ();

  icache #(.NSETS(NSETS), .BLOCK_WORDS(BW), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .nRST(nRST), .cif(bus.slave),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  typedef struct {
    logic        ihit;
    logic [31:0] load;
    logic        ren;
    logic [31:0] raddr;
    logic [31:0] hc;
    logic [31:0] mc;
  } exp_t;

  exp_t sb[$];
  int tests = 0;
  int fails = 0;

  // Reference model: which lines are resident, plus the outstanding refill
  // as a list of word addresses still to be returned by memory.
  bit          mvalid [NSETS];
  logic [24:0] mtag   [NSETS];
  bit          busy, mdisc;
  logic [31:0] pend[$];
  int          waitc, lat_fixed, mhc, mmc, fidx;
  logic [24:0] ftag;

  function automatic logic [31:0] memval(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic int pick_lat();
    return (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 4));
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares DUT outputs mid-cycle against the queued expectation.
  always @(negedge CLK) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check32("ihit",       32'(bus.ihit),   32'(e.ihit));
      check32("imemload",   bus.imemload,    e.load);
      check32("ramREN",     32'(bus.ramREN), 32'(e.ren));
      check32("ramaddr",    bus.ramaddr,     e.raddr);
      check32("hit_count",  32'(hit_count),  e.hc);
      check32("miss_count", 32'(miss_count), e.mc);
    end
  end

  task automatic model_clear();
    for (int i = 0; i < NSETS; i++) begin mvalid[i] = 0; mtag[i] = '0; end
    busy = 0; mdisc = 0; pend.delete(); waitc = 0; mhc = 0; mmc = 0;
  endtask

  // One clock cycle: entered and left at posedge+1.
  task automatic cycle(input bit req, input logic [31:0] addr, input bit inv);
    exp_t e;
    bit rdy;
    int idx;
    logic [24:0] tg;
    logic [31:0] base;
    idx  = int'(addr[6:3]);
    tg   = addr[31:7];
    base = addr & ~32'(BW * 4 - 1);
    rdy  = busy && (waitc == 0);
    bus.imemREN    = req;
    bus.imemaddr   = addr;
    bus.invalidate = inv;
    if (busy) begin
      bus.ram_ready = rdy;
      bus.ramload   = rdy ? memval(pend[0]) : $urandom;
    end else begin
      bus.ram_ready = 1'($urandom_range(0, 1));
      bus.ramload   = $urandom;
    end
    e.ihit  = req && !busy && !inv && mvalid[idx] && (mtag[idx] == tg);
    e.load  = e.ihit ? memval({addr[31:2], 2'b00}) : 32'h0;
    e.ren   = busy;
    e.raddr = busy ? pend[0] : 32'h0;
    e.hc    = 32'(mhc);
    e.mc    = 32'(mmc);
    sb.push_back(e);
    @(posedge CLK); #1;
    if (e.ihit && mhc < CMAX) mhc++;
    if (inv) for (int i = 0; i < NSETS; i++) mvalid[i] = 0;
    if (!busy) begin
      if (req && !e.ihit && !inv) begin
        busy = 1; mdisc = 0; fidx = idx; ftag = tg;
        for (int w = 0; w < BW; w++) pend.push_back(base + 32'(4 * w));
        waitc = pick_lat() - 1;
        if (mmc < CMAX) mmc++;
      end
    end else begin
      if (inv) mdisc = 1;
      if (rdy) begin
        void'(pend.pop_front());
        if (pend.size() == 0) begin
          busy = 0;
          if (!mdisc) begin mvalid[fidx] = 1; mtag[fidx] = ftag; end
        end else waitc = pick_lat() - 1;
      end else waitc--;
    end
  endtask

  task automatic drain(input bit req, input logic [31:0] addr);
    int n = 0;
    while (busy && n < 60) begin cycle(req, addr, 0); n++; end
    tests++;
    if (busy) begin fails++; $display("FAIL refill_timeout: busy after %0d cycles", n); end
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    bus.imemREN = 0; bus.imemaddr = 0; bus.invalidate = 0;
    bus.ram_ready = 0; bus.ramload = 0;
    repeat (2) @(posedge CLK);
    #1;
    model_clear();
    nRST = 1'b1;
    check32("rst hit_count",  32'(hit_count),  0);
    check32("rst miss_count", 32'(miss_count), 0);
    check32("rst ramREN",     32'(bus.ramREN), 0);
    check32("rst ramaddr",    bus.ramaddr,     0);
    check32("rst imemload",   bus.imemload,    0);
  endtask

  initial begin
    logic [31:0] a;
    int n;
    do_reset();

    // Cold miss, then the neighbouring word hits without a new refill
    lat_fixed = 1;
    cycle(1, 32'h0, 0); drain(1, 32'h0);
    cycle(1, 32'h0, 0); cycle(1, 32'h4, 0);
    check32("cold miss_count", 32'(miss_count), 1);

    // Conflict eviction on index 0
    cycle(1, 32'h80, 0); drain(1, 32'h80); cycle(1, 32'h84, 0);
    cycle(1, 32'h0, 0);  drain(1, 32'h0);  cycle(1, 32'h0, 0);
    check32("conflict miss_count", 32'(miss_count), 3);

    // Slow memory; request moves mid-refill and is served afterwards
    lat_fixed = 4;
    cycle(1, 32'h100, 0); drain(1, 32'h200);
    cycle(1, 32'h200, 0); drain(1, 32'h200); cycle(1, 32'h200, 0);
    check32("varlat miss_count", 32'(miss_count), 5);

    // Invalidate in IDLE
    lat_fixed = 1;
    cycle(1, 32'h0, 0); drain(1, 32'h0); cycle(1, 32'h0, 0);
    cycle(1, 32'h0, 1);
    cycle(1, 32'h0, 0);
    check32("inv idle refetch ramREN", 32'(bus.ramREN), 1);
    drain(1, 32'h0);

    // Invalidate during a refill of 0x40
    lat_fixed = 3;
    cycle(1, 32'h40, 0); cycle(1, 32'h40, 0); cycle(1, 32'h40, 1);
    drain(1, 32'h40);
    cycle(1, 32'h40, 0);
    check32("inv refill refetch ramREN", 32'(bus.ramREN), 1);
    drain(1, 32'h40);

    // Counter saturation
    do_reset();
    lat_fixed = 1;
    cycle(1, 32'h0, 0); drain(1, 32'h0);
    for (int i = 0; i < 20; i++) cycle(1, 32'h0, 0);
    check32("sat hit_count", 32'(hit_count), 15);
    check32("sat miss_count", 32'(miss_count), 1);

    // Reset during word 1 of a refill
    lat_fixed = 3;
    cycle(1, 32'h8, 0);
    n = 0;
    while (pend.size() == BW && n < 20) begin cycle(1, 32'h8, 0); n++; end
    cycle(1, 32'h8, 0);
    check32("midrst pre ramaddr", bus.ramaddr, 32'hC);
    nRST = 1'b0;
    #1;
    check32("midrst ramREN",     32'(bus.ramREN), 0);
    check32("midrst hit_count",  32'(hit_count),  0);
    check32("midrst miss_count", 32'(miss_count), 0);
    @(posedge CLK); #1;
    model_clear();
    nRST = 1'b1;
    cycle(1, 32'h0, 0);
    check32("midrst 0 misses", 32'(bus.ramREN), 1);
    drain(1, 32'h0);
    cycle(1, 32'h8, 0); drain(1, 32'h8);

    // Randomised traffic over a small tag pool so hits, conflicts and
    // invalidates all occur
    do_reset();
    lat_fixed = 0;
    for (int i = 0; i < 3000; i++) begin
      a = (32'($urandom_range(0, 3)) << 7) | (32'($urandom_range(0, 15)) << 3) |
          (32'($urandom_range(0, 1)) << 2) | 32'($urandom_range(0, 3));
      cycle(($urandom % 8) != 0, a, ($urandom % 40) == 0);
    end
    drain(0, 32'h0);

    @(negedge CLK);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
